// File: rtl/exp_conv_mac_array.sv
// rtl/exp_conv_mac_array.sv - KxK fixed-point MAC array with adder-tree pipeline and credit-guarded output FIFO
module exp_conv_mac_array #(
    parameter int DATA_W      = 8,
    parameter int TAPS        = 9,
    parameter int NUM_KERNELS = 4,
    parameter int OUT_W       = 12,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  start_i,
    input  logic                                  relu_en_i,
    input  logic [3:0]                            shift_i,
    input  logic                                  data_valid_i,
    output logic                                  data_ready_o,
    input  logic [TAPS*DATA_W-1:0]                layer_data_i,
    input  logic [NUM_KERNELS*TAPS*DATA_W-1:0]    kernel_data_i,
    input  logic                                  fifo_rd_en_i,
    output logic [NUM_KERNELS*OUT_W-1:0]          fifo_rd_data_o,
    output logic                                  fifo_empty_o,
    output logic                                  fifo_full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_data_count_o
);

    localparam int L     = $clog2(TAPS);
    localparam int ACC_W = 2*DATA_W + L;
    localparam int NS    = L + 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH+1);
    localparam int RW    = NUM_KERNELS*OUT_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam acc_t ACC_MAX = acc_t'(OUT_MAX);
    localparam acc_t ACC_MIN = acc_t'(OUT_MIN);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

    function automatic int level_nodes(input int lvl);
        int n;
        n = TAPS;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic            accept;
    logic [NS-1:0]   vld_d, vld_q;
    acc_t            tree_d [L+1][NUM_KERNELS][TAPS];
    acc_t            tree_q [L+1][NUM_KERNELS][TAPS];
    logic [RW-1:0]   sp_d, sp_q;
    logic [RW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]   count_d, count_q;
    logic            wr_en, rd_en;
    logic [CW:0]     credit;

    // Slots are reserved at accept time, so a pipeline write can never find the FIFO full.
    always_comb begin
        credit = {1'b0, count_q};
        for (int i = 0; i < NS; i++) credit = credit + (CW+1)'(vld_q[i]);
    end

    assign data_ready_o = (credit < DEPTH_C);
    assign accept       = data_valid_i && data_ready_o && !start_i;

    always_comb begin
        logic signed [DATA_W-1:0]   a, b;
        logic signed [2*DATA_W-1:0] prod;
        int n;
        for (int lv = 0; lv <= L; lv++)
            for (int k = 0; k < NUM_KERNELS; k++)
                for (int t = 0; t < TAPS; t++)
                    tree_d[lv][k][t] = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            for (int t = 0; t < TAPS; t++) begin
                a    = layer_data_i[(TAPS-1-t)*DATA_W +: DATA_W];
                b    = kernel_data_i[((NUM_KERNELS-1-k)*TAPS + (TAPS-1-t))*DATA_W +: DATA_W];
                prod = a * b;
                tree_d[0][k][t] = acc_t'(prod);
            end
        end
        // Pairwise reduction; an odd leftover operand is carried forward unchanged.
        for (int lv = 1; lv <= L; lv++) begin
            n = level_nodes(lv - 1);
            for (int k = 0; k < NUM_KERNELS; k++) begin
                for (int i = 0; i < TAPS/2; i++)
                    if (2*i + 1 < n)
                        tree_d[lv][k][i] = tree_q[lv-1][k][2*i] + tree_q[lv-1][k][2*i+1];
                if (n % 2 == 1)
                    tree_d[lv][k][n/2] = tree_q[lv-1][k][n-1];
            end
        end
    end

    always_comb begin
        acc_t                    shifted;
        logic signed [OUT_W-1:0] val;
        sp_d = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            shifted = tree_q[L][k][0] >>> shift_i;
            if (shifted > ACC_MAX)      val = OUT_MAX;
            else if (shifted < ACC_MIN) val = OUT_MIN;
            else                        val = shifted[OUT_W-1:0];
            if (relu_en_i && val[OUT_W-1]) val = '0;
            sp_d[(NUM_KERNELS-1-k)*OUT_W +: OUT_W] = val;
        end
    end

    always_ff @(posedge clk_i) begin
        tree_q <= tree_d;
        sp_q   <= sp_d;
        if (wr_en) mem_q[wr_ptr_q] <= sp_q;
    end

    assign wr_en = vld_q[NS-1] && !start_i;
    assign rd_en = fifo_rd_en_i && (count_q != '0) && !start_i;

    always_comb begin
        vld_d    = start_i ? '0 : {vld_q[NS-2:0], accept};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (start_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fifo_empty_o      = (count_q == '0);
    assign fifo_full_o       = (count_q == FULL_C);
    assign fifo_data_count_o = count_q;
    assign fifo_rd_data_o    = fifo_empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_exp_conv_mac_array.sv
// tb/tb_exp_conv_mac_array.sv - directed self-checking bench for exp_conv_mac_array
module tb_exp_conv_mac_array;

    localparam int DATA_W = 8;
    localparam int TAPS   = 9;
    localparam int NK     = 4;
    localparam int OUT_W  = 12;
    localparam int DEPTH  = 16;
    localparam int LW     = TAPS*DATA_W;
    localparam int KW     = NK*TAPS*DATA_W;
    localparam int RW     = NK*OUT_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          relu = 1'b0;
    logic [3:0]    shift = 4'd0;
    logic          dv = 1'b0;
    logic          dr;
    logic [LW-1:0] layer = '0;
    logic [KW-1:0] kern = '0;
    logic          rd_en = 1'b0;
    logic [RW-1:0] rd_data;
    logic          empty, full;
    logic [4:0]    cnt;

    int checks = 0;
    int errors = 0;

    exp_conv_mac_array #(
        .DATA_W(DATA_W), .TAPS(TAPS), .NUM_KERNELS(NK), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .relu_en_i(relu), .shift_i(shift),
        .data_valid_i(dv), .data_ready_o(dr), .layer_data_i(layer), .kernel_data_i(kern),
        .fifo_rd_en_i(rd_en), .fifo_rd_data_o(rd_data), .fifo_empty_o(empty),
        .fifo_full_o(full), .fifo_data_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rep_layer(input int v);
        logic [LW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic logic [KW-1:0] rep_kern(input int k0, input int k1, input int k2, input int k3);
        logic [KW-1:0] r;
        int v[4];
        v = '{k0, k1, k2, k3};
        for (int k = 0; k < NK; k++)
            for (int t = 0; t < TAPS; t++)
                r[((NK-1-k)*TAPS + t)*DATA_W +: DATA_W] = DATA_W'(v[k]);
        return r;
    endfunction

    function automatic logic [LW-1:0] tag_layer(input int s);
        logic [LW-1:0] r;
        r = '0;
        r[LW-1 -: DATA_W] = DATA_W'(s);
        return r;
    endfunction

    function automatic logic [RW-1:0] tag_result(input int s);
        logic [RW-1:0] r;
        r = '0;
        r[RW-1 -: OUT_W] = OUT_W'(s);
        return r;
    endfunction

    function automatic logic [RW-1:0] model(input logic [LW-1:0] l, input logic [KW-1:0] k,
                                            input int sh, input bit rl);
        logic [RW-1:0]      r;
        logic signed [7:0]  a, b;
        int                 acc;
        for (int kk = 0; kk < NK; kk++) begin
            acc = 0;
            for (int t = 0; t < TAPS; t++) begin
                a = l[(TAPS-1-t)*DATA_W +: DATA_W];
                b = k[((NK-1-kk)*TAPS + TAPS-1-t)*DATA_W +: DATA_W];
                acc += int'(a) * int'(b);
            end
            acc = acc >>> sh;
            if (acc > 2047)  acc = 2047;
            if (acc < -2048) acc = -2048;
            if (rl && acc < 0) acc = 0;
            r[(NK-1-kk)*OUT_W +: OUT_W] = acc[OUT_W-1:0];
        end
        return r;
    endfunction

    task automatic run_one(input string name, input logic [LW-1:0] l, input logic [KW-1:0] k,
                           input int sh, input bit rl, input logic [RW-1:0] exp_v);
        shift = 4'(sh);
        relu  = rl;
        layer = l;
        kern  = k;
        dv    = 1'b1;
        step();
        dv = 1'b0;
        repeat (5) step();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency empty got %b exp 1 at edge 5", name, empty);
        end
        step();
        checks++;
        if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL %s_data got %h exp %h", name, rd_data, exp_v);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_pop empty got %b exp 1", name, empty);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++;
        if (cnt !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++;
        if (dr !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        shift = 4'd0;
        relu  = 1'b0;
        layer = rep_layer(1);
        kern  = rep_kern(2, -1, 0, 0);
        dv    = 1'b1;
        step();
        dv = 1'b0;
        repeat (5) step();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL basic_latency got empty %b exp 1", empty); end
        step();
        checks++;
        if (rd_data !== 48'h012_FF7_000_000) begin
            errors++;
            $display("FAIL basic_data got %h exp %h", rd_data, 48'h012_FF7_000_000);
        end
        checks++;
        if (cnt !== 5'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", cnt); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_sat_shift();
        run_one("sat_pos_neg", rep_layer(127), rep_kern(127, -128, 1, -1), 0, 1'b0, 48'h7FF_800_477_B89);
        run_one("shift2", rep_layer(1), rep_kern(2, -1, 0, 3), 2, 1'b0, 48'h004_FFD_000_006);
        run_one("shift_floor", rep_layer(5), rep_kern(-1, 0, 0, 0), 2, 1'b0, 48'hFF4_000_000_000);
    endtask

    task automatic test_relu();
        run_one("relu", rep_layer(5), rep_kern(-1, 1, -2, 2), 0, 1'b1, 48'h000_02D_000_05A);
        relu = 1'b0;
    endtask

    task automatic test_backpressure();
        int  seq;
        bit  acc;
        seq  = 0;
        kern = '0;
        kern[KW-1 -: DATA_W] = 8'd1;
        dv = 1'b1;
        for (int i = 0; i < 30; i++) begin
            layer = tag_layer(seq);
            acc   = dr;
            step();
            if (acc) seq++;
        end
        checks++;
        if (seq != 16) begin errors++; $display("FAIL bp_accepts got %0d exp 16", seq); end
        checks++;
        if (cnt !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL bp_full got count %0d full %b exp 16 1", cnt, full);
        end
        checks++;
        if (dr !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", dr); end
        checks++;
        if (rd_data !== tag_result(0)) begin
            errors++;
            $display("FAIL bp_head got %h exp %h", rd_data, tag_result(0));
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dr !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", dr); end
        for (int i = 0; i < 10; i++) begin
            layer = tag_layer(seq);
            acc   = dr;
            step();
            if (acc) seq++;
        end
        dv = 1'b0;
        checks++;
        if (seq != 17 || cnt !== 5'd16) begin
            errors++;
            $display("FAIL bp_refill got accepts %0d count %0d exp 17 16", seq, cnt);
        end
        rd_en = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            checks++;
            if (rd_data !== tag_result(s)) begin
                errors++;
                $display("FAIL bp_order got %h exp %h", rd_data, tag_result(s));
            end
            step();
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || cnt !== 5'd0) begin
            errors++;
            $display("FAIL bp_drained got empty %b count %0d exp 1 0", empty, cnt);
        end
    endtask

    task automatic test_clear();
        bit stale;
        kern = '0;
        kern[KW-1 -: DATA_W] = 8'd1;
        layer = tag_layer(7);
        dv = 1'b1;
        repeat (3) step();
        dv = 1'b0;
        repeat (8) step();
        checks++;
        if (cnt !== 5'd3) begin errors++; $display("FAIL clr_prefill got %0d exp 3", cnt); end
        dv = 1'b1;
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        dv    = 1'b0;
        checks++;
        if (cnt !== 5'd0 || empty !== 1'b1 || dr !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL clr_start got count %0d empty %b ready %b exp 0 1 1", cnt, empty, dr);
        end
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cnt !== 5'd0) stale = 1'b1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL clr_stale got count %0d exp 0", cnt); end

        dv = 1'b1;
        repeat (3) step();
        dv = 1'b0;
        repeat (8) step();
        dv = 1'b1;
        repeat (2) step();
        dv = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || dr !== 1'b1) begin
            errors++;
            $display("FAIL clr_async got count %0d empty %b full %b ready %b exp 0 1 0 1",
                     cnt, empty, full, dr);
        end
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cnt !== 5'd0) stale = 1'b1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL clr_async_stale got count %0d exp 0", cnt); end
    endtask

    task automatic test_streaming();
        logic [RW-1:0] q[$];
        int popped, pushed, stalls;
        popped = 0;
        pushed = 0;
        stalls = 0;
        shift  = 4'd3;
        relu   = 1'b0;
        rd_en  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i < 40) begin
                dv = 1'b1;
                for (int t = 0; t < TAPS; t++) layer[t*DATA_W +: DATA_W] = 8'($urandom);
                for (int t = 0; t < NK*TAPS; t++) kern[t*DATA_W +: DATA_W] = 8'($urandom);
                if (!dr) stalls++;
            end else begin
                dv = 1'b0;
            end
            if (!empty) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected got %h exp none", rd_data);
                end else begin
                    if (rd_data !== q[0]) begin
                        errors++;
                        $display("FAIL stream_data got %h exp %h", rd_data, q[0]);
                    end
                    void'(q.pop_front());
                end
                popped++;
            end
            if (dv && dr) begin
                q.push_back(model(layer, kern, 3, 1'b0));
                pushed++;
            end
            step();
        end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d exp 0", stalls); end
        checks++;
        if (pushed != 40 || popped != 40) begin
            errors++;
            $display("FAIL stream_counts got pushed %0d popped %0d exp 40 40", pushed, popped);
        end
        repeat (3) step();
        checks++;
        if (cnt !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_read_empty got count %0d empty %b exp 0 1", cnt, empty);
        end
        rd_en = 1'b0;
        shift = 4'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_shift();
        test_relu();
        test_backpressure();
        test_clear();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
